// File: rtl/panda_div.sv
// rtl/panda_div.sv - pulse-train divider routing every DIVISOR-th rising edge to outd_o, the rest to outn_o
// Outputs are registered copies of inp_i, so each routed pulse keeps its input width and is delayed one cycle.
module panda_div (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        inp_i,
  input  logic        FIRST_PULSE,
  input  logic [31:0] DIVISOR,
  input  logic        FORCE_RST,
  output logic        outd_o,
  output logic        outn_o,
  output logic [31:0] COUNT
);

  logic        inp_d;
  logic        route_d;
  logic        route_n;
  logic [31:0] counter;
  logic [31:0] div_m1;
  logic        rise;
  logic        terminal;

  // DIVISOR=0 behaves as a divide-by-one
  assign div_m1   = (DIVISOR == 32'd0) ? 32'd0 : DIVISOR - 32'd1;
  assign rise     = inp_i & ~inp_d;
  // ">=" also catches a counter left above a freshly lowered divisor
  assign terminal = (counter >= div_m1);
  assign COUNT    = counter;

  always_ff @(posedge clk_i) begin
    if (rst_i || FORCE_RST) begin
      counter <= FIRST_PULSE ? div_m1 : 32'd0;
      inp_d   <= inp_i;
      route_d <= 1'b0;
      route_n <= 1'b0;
      outd_o  <= 1'b0;
      outn_o  <= 1'b0;
    end else begin
      inp_d <= inp_i;
      if (rise) begin
        route_d <= terminal;
        route_n <= ~terminal;
        outd_o  <= terminal;
        outn_o  <= ~terminal;
        counter <= terminal ? 32'd0 : counter + 32'd1;
      end else begin
        outd_o <= route_d & inp_i;
        outn_o <= route_n & inp_i;
      end
    end
  end

endmodule

// File: tb/tb_panda_div.sv
// tb/tb_panda_div.sv - self-checking bench for panda_div: directed scenarios plus randomized run against a pulse-level model
module tb_panda_div;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        inp_i = 1'b0;
  logic        FIRST_PULSE = 1'b0;
  logic [31:0] DIVISOR = 32'd3;
  logic        FORCE_RST = 1'b0;
  logic        outd_o;
  logic        outn_o;
  logic [31:0] COUNT;

  int checks = 0;
  int failures = 0;

  // model state: pulse count since last terminal, routing of the pulse in progress (0 none, 1 n, 2 d)
  longint m_cnt = 0;
  int     m_route = 0;
  logic   m_prev = 1'b0;
  logic   m_outd = 1'b0;
  logic   m_outn = 1'b0;

  panda_div dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .inp_i      (inp_i),
    .FIRST_PULSE(FIRST_PULSE),
    .DIVISOR    (DIVISOR),
    .FORCE_RST  (FORCE_RST),
    .outd_o     (outd_o),
    .outn_o     (outn_o),
    .COUNT      (COUNT)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    longint eff;
    eff = (DIVISOR == 0) ? 1 : longint'(DIVISOR);
    if (rst_i || FORCE_RST) begin
      m_cnt   = FIRST_PULSE ? eff - 1 : 0;
      m_route = 0;
      m_outd  = 1'b0;
      m_outn  = 1'b0;
    end else begin
      if (inp_i && !m_prev) begin
        if (m_cnt >= eff - 1) begin
          m_route = 2;
          m_cnt   = 0;
        end else begin
          m_route = 1;
          m_cnt   = (m_cnt + 1) & 64'hFFFF_FFFF;
        end
      end
      m_outd = (m_route == 2) && inp_i;
      m_outn = (m_route == 1) && inp_i;
    end
    m_prev = inp_i;
  endtask

  task automatic tick();
    @(posedge clk_i);
    model_edge();
    @(negedge clk_i);
    check("model_outd", {31'd0, outd_o}, {31'd0, m_outd});
    check("model_outn", {31'd0, outn_o}, {31'd0, m_outn});
    check("model_count", COUNT, m_cnt[31:0]);
    check("exclusive", {31'd0, outd_o & outn_o}, 32'd0);
  endtask

  // one pulse of width w then gap low cycles; reports the output that fired, COUNT after the edge, and high-cycle counts
  task automatic pulse(input int w, input int gap, output int fired, output logic [31:0] cnt,
                       output int hd, output int hn);
    hd = 0;
    hn = 0;
    inp_i = 1'b1;
    tick();
    fired = outd_o ? 2 : (outn_o ? 1 : 0);
    cnt = COUNT;
    hd += int'(outd_o);
    hn += int'(outn_o);
    for (int i = 1; i < w; i++) begin
      tick();
      hd += int'(outd_o);
      hn += int'(outn_o);
    end
    inp_i = 1'b0;
    for (int i = 0; i < gap; i++) begin
      tick();
      hd += int'(outd_o);
      hn += int'(outn_o);
    end
  endtask

  task automatic do_reset(input logic fp, input logic [31:0] dv);
    FIRST_PULSE = fp;
    DIVISOR = dv;
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  initial begin
    int fired, hd, hn;
    logic [31:0] cnt;
    int r29 [6] = '{1, 1, 2, 1, 1, 2};
    int c29 [6] = '{1, 2, 0, 1, 2, 0};
    int r30 [4] = '{2, 1, 1, 2};
    int r32 [4] = '{1, 1, 1, 2};

    @(negedge clk_i);
    do_reset(1'b0, 32'd3);
    check("reset_count", COUNT, 32'd0);
    check("reset_outd", {31'd0, outd_o}, 32'd0);
    check("reset_outn", {31'd0, outn_o}, 32'd0);

    for (int i = 0; i < 6; i++) begin
      pulse(1, 2, fired, cnt, hd, hn);
      check($sformatf("div3_route%0d", i), fired, r29[i]);
      check($sformatf("div3_count%0d", i), cnt, c29[i]);
      check($sformatf("div3_width%0d", i), hd + hn, 1);
    end

    do_reset(1'b1, 32'd3);
    check("fp1_count", COUNT, 32'd2);
    for (int i = 0; i < 4; i++) begin
      pulse(1, 1, fired, cnt, hd, hn);
      check($sformatf("fp1_route%0d", i), fired, r30[i]);
    end

    for (int d = 0; d < 2; d++) begin
      do_reset(1'b0, d);
      for (int i = 0; i < 3; i++) begin
        pulse(1, 1, fired, cnt, hd, hn);
        check($sformatf("div%0d_route%0d", d, i), fired, 2);
        check($sformatf("div%0d_count%0d", d, i), cnt, 32'd0);
      end
    end

    do_reset(1'b0, 32'd4);
    pulse(1, 1, fired, cnt, hd, hn);
    pulse(1, 1, fired, cnt, hd, hn);
    check("frst_before", COUNT, 32'd2);
    FORCE_RST = 1'b1;
    tick();
    FORCE_RST = 1'b0;
    check("frst_after", COUNT, 32'd0);
    for (int i = 0; i < 4; i++) begin
      pulse(1, 1, fired, cnt, hd, hn);
      check($sformatf("frst_route%0d", i), fired, r32[i]);
    end

    do_reset(1'b0, 32'd2);
    pulse(5, 3, fired, cnt, hd, hn);
    check("wide_route", fired, 1);
    check("wide_outn_cycles", hn, 5);
    check("wide_outd_cycles", hd, 0);

    inp_i = 1'b1;
    tick();
    tick();
    check("midrst_live", {31'd0, outd_o | outn_o}, 32'd1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("midrst_drop", {31'd0, outd_o | outn_o}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("midrst_quiet%0d", i), {31'd0, outd_o | outn_o}, 32'd0);
    end
    inp_i = 1'b0;
    tick();
    pulse(1, 1, fired, cnt, hd, hn);
    check("midrst_next", {31'd0, fired != 0}, 32'd1);

    // randomized run: random pulse train, divisor changes, occasional resets
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 99) < 35) inp_i = ~inp_i;
      if ($urandom_range(0, 199) == 0) DIVISOR = $urandom_range(0, 6);
      if ($urandom_range(0, 299) == 0) FIRST_PULSE = ~FIRST_PULSE;
      FORCE_RST = ($urandom_range(0, 249) == 0);
      rst_i = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst_i = 1'b0;
    FORCE_RST = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
